// File: rtl/mac_stream_driver_if.sv
// Operand-beat and result streams between a producer/consumer and mac_stream_driver.
interface mac_stream_driver_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [4*bw-1:0]   in_x;
  logic [4*bw-1:0]   in_w;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [psum_bw-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, in_x, in_w, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_x, in_w, in_last, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/mac_stream_driver.sv
// Streams 4-lane operand beats into an external combinational mac_wrapper and
// returns the accumulated dot product, force-terminating vectors at max_beats.
module mac_stream_driver #(
  parameter int bw        = 4,
  parameter int psum_bw   = 16,
  parameter int max_beats = 16
) (
  input  logic               clk,
  input  logic               reset,
  mac_stream_driver_if.slave bus,
  output logic [bw-1:0]      x0,
  output logic [bw-1:0]      x1,
  output logic [bw-1:0]      x2,
  output logic [bw-1:0]      x3,
  output logic [bw-1:0]      w0,
  output logic [bw-1:0]      w1,
  output logic [bw-1:0]      w2,
  output logic [bw-1:0]      w3,
  output logic [psum_bw-1:0] psum_in,
  input  logic [psum_bw-1:0] mac_out
);

  localparam int cw = $clog2(max_beats);
  localparam logic [cw-1:0] cnt_zero_c = {cw{1'b0}};
  localparam logic [cw-1:0] cnt_one_c  = {{(cw-1){1'b0}}, 1'b1};
  localparam logic [cw-1:0] cnt_last_c = cw'(max_beats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [cw-1:0]        cnt_r;
  logic [cw-1:0]        cnt_s;
  logic [cw-1:0]        base_cnt_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 overrun_s;
  logic                 final_s;

  logic [bw-1:0]        x_r [0:3];
  logic [bw-1:0]        w_r [0:3];
  logic                 stage_valid_r;
  logic                 first_r;
  logic [psum_bw-1:0]   psum_r;
  logic [psum_bw-1:0]   psum_in_s;

  logic                 err_pend_r;
  logic                 out_valid_r;
  logic                 out_valid_s;
  logic                 out_load_s;
  logic [psum_bw-1:0]   out_data_r;
  logic                 out_err_r;

  // Input handshake and vector-termination decode; in_ready depends on state only.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      ACC:     in_ready_s = 1'b1;
      DRAIN:   in_ready_s = 1'b0;
      DONE:    in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase

    accept_s = bus.in_valid && in_ready_s;

    // A beat taken in IDLE always starts a fresh count, whatever cnt_r holds.
    if (state_r == IDLE) begin
      base_cnt_s = cnt_zero_c;
    end else begin
      base_cnt_s = cnt_r;
    end

    overrun_s = accept_s && !bus.in_last && (base_cnt_s == cnt_last_c);
    final_s   = accept_s && (bus.in_last || overrun_s);

    if (accept_s) begin
      cnt_s = base_cnt_s + cnt_one_c;
    end else if (state_r == IDLE) begin
      cnt_s = cnt_zero_c;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (final_s) begin
          state_s = DRAIN;
        end else if (accept_s) begin
          state_s = ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (final_s) begin
          state_s = DRAIN;
        end else begin
          state_s = ACC;
        end
      end
      DRAIN: state_s = DONE;
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= cnt_zero_c;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Operand stage: holds the accepted beat for one cycle, zeros otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        x_r[k] <= {bw{1'b0}};
        w_r[k] <= {bw{1'b0}};
      end
      stage_valid_r <= 1'b0;
      first_r       <= 1'b0;
    end else if (accept_s) begin
      for (int k = 0; k < 4; k++) begin
        x_r[k] <= bus.in_x[bw*k +: bw];
        w_r[k] <= bus.in_w[bw*k +: bw];
      end
      stage_valid_r <= 1'b1;
      first_r       <= (state_r == IDLE);
    end else begin
      for (int k = 0; k < 4; k++) begin
        x_r[k] <= {bw{1'b0}};
        w_r[k] <= {bw{1'b0}};
      end
      stage_valid_r <= 1'b0;
      first_r       <= 1'b0;
    end
  end

  // First beat of a vector starts from zero so no stale sum leaks between vectors.
  always_comb begin
    if (!stage_valid_r || first_r) begin
      psum_in_s = {psum_bw{1'b0}};
    end else begin
      psum_in_s = psum_r;
    end
  end

  // Partial-sum register captures the mac result of each staged beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum_r <= {psum_bw{1'b0}};
    end else if (stage_valid_r) begin
      psum_r <= mac_out;
    end else begin
      psum_r <= psum_r;
    end
  end

  // Result handshake: the result is published one cycle after DONE is entered.
  always_comb begin
    out_load_s  = (state_r == DONE) && !out_valid_r;
    out_valid_s = (state_r == DONE) && !(out_valid_r && bus.out_ready);
  end

  // Result registers; data and error only change when a new result is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pend_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {psum_bw{1'b0}};
      out_err_r   <= 1'b0;
    end else begin
      if (final_s) begin
        err_pend_r <= overrun_s;
      end else begin
        err_pend_r <= err_pend_r;
      end
      out_valid_r <= out_valid_s;
      if (out_load_s) begin
        out_data_r <= psum_r;
        out_err_r  <= err_pend_r;
      end else begin
        out_data_r <= out_data_r;
        out_err_r  <= out_err_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_err   = out_err_r;

  assign x0 = x_r[0];
  assign x1 = x_r[1];
  assign x2 = x_r[2];
  assign x3 = x_r[3];
  assign w0 = w_r[0];
  assign w1 = w_r[1];
  assign w2 = w_r[2];
  assign w3 = w_r[3];
  assign psum_in = psum_in_s;

endmodule

// File: tb/tb_mac_stream_driver.sv
// Directed and randomized bench for mac_stream_driver paired with a behavioural mac_wrapper.
module tb_mac_stream_driver;
  localparam int bw        = 4;
  localparam int psum_bw   = 16;
  localparam int max_beats = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_stream_driver_if #(.bw(bw), .psum_bw(psum_bw)) bus ();

  logic [bw-1:0]      x0, x1, x2, x3, w0, w1, w2, w3;
  logic [psum_bw-1:0] psum_in;
  logic [psum_bw-1:0] mac_out;

  mac_stream_driver #(.bw(bw), .psum_bw(psum_bw), .max_beats(max_beats)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .x0      (x0),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .w0      (w0),
    .w1      (w1),
    .w2      (w2),
    .w3      (w3),
    .psum_in (psum_in),
    .mac_out (mac_out)
  );

  // mac_wrapper behaviour: psum plus the four lane products, modulo 2^16
  always_comb begin
    mac_out = psum_in + 16'(x0) * 16'(w0) + 16'(x1) * 16'(w1)
                      + 16'(x2) * 16'(w2) + 16'(x3) * 16'(w3);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one vector and checks every stage against a dot-product model.
  task automatic run_vector(input string name, input int n, input bit use_last, input bit rnd,
                            input logic [15:0] fx, input logic [15:0] fw, input int gap_mask,
                            input int hold, input int exp_lit, input int exp_err_lit);
    int sum;
    int prev;
    int accepted;
    bit done;
    bit err_exp;
    logic [15:0] bx;
    logic [15:0] bwv;
    sum = 0;
    accepted = 0;
    done = 1'b0;
    err_exp = 1'b0;
    bus.out_ready = (hold == 0);
    for (int i = 0; i < n && !done; i++) begin
      if (rnd) begin
        bx  = 16'($urandom);
        bwv = 16'($urandom);
      end else begin
        bx  = fx;
        bwv = fw;
      end
      if (gap_mask[i]) begin
        bus.in_valid = 1'b0;
        tick();
        check({name, ":gap_x"}, 32'({x3, x2, x1, x0}), 32'd0);
        check({name, ":gap_psum_in"}, 32'(psum_in), 32'd0);
        check({name, ":gap_in_ready"}, 32'(bus.in_ready), 32'd1);
      end
      bus.in_valid = 1'b1;
      bus.in_x     = bx;
      bus.in_w     = bwv;
      bus.in_last  = use_last && (i == n - 1);
      check({name, ":in_ready"}, 32'(bus.in_ready), 32'd1);
      prev = sum;
      for (int k = 0; k < 4; k++) begin
        sum += int'(bx[4*k +: 4]) * int'(bwv[4*k +: 4]);
      end
      accepted++;
      if (bus.in_last) begin
        done = 1'b1;
      end else if (accepted == max_beats) begin
        done = 1'b1;
        err_exp = 1'b1;
      end
      tick();
      check({name, ":stage_x"}, 32'({x3, x2, x1, x0}), 32'(bx));
      check({name, ":stage_w"}, 32'({w3, w2, w1, w0}), 32'(bwv));
      check({name, ":psum_in"}, 32'(psum_in), (i == 0) ? 32'd0 : 32'(prev & 32'h0000FFFF));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check({name, ":drain_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, ":drain_out_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({name, ":t1_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, ":t1_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, ":t1_x"}, 32'({x3, x2, x1, x0}), 32'd0);
    tick();
    check({name, ":out_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, ":out_data"}, 32'(bus.out_data), 32'(sum & 32'h0000FFFF));
    check({name, ":out_err"}, 32'(bus.out_err), 32'(err_exp));
    check({name, ":done_in_ready"}, 32'(bus.in_ready), 32'd0);
    if (exp_lit >= 0) check({name, ":out_data_lit"}, 32'(bus.out_data), 32'(exp_lit));
    if (exp_err_lit >= 0) check({name, ":out_err_lit"}, 32'(bus.out_err), 32'(exp_err_lit));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, ":hold_data"}, 32'(bus.out_data), 32'(sum & 32'h0000FFFF));
      check({name, ":hold_err"}, 32'(bus.out_err), 32'(err_exp));
      check({name, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check({name, ":ret_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, ":ret_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ul;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = 16'h0000;
    bus.in_w      = 16'h0000;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst:x", 32'({x3, x2, x1, x0}), 32'd0);
    check("rst:w", 32'({w3, w2, w1, w0}), 32'd0);
    check("rst:psum_in", 32'(psum_in), 32'd0);
    check("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("rst:out_data", 32'(bus.out_data), 32'd0);
    check("rst:out_err", 32'(bus.out_err), 32'd0);
    check("rst:in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;
    tick();
    check("post_rst:in_ready", 32'(bus.in_ready), 32'd1);

    run_vector("single", 1, 1'b1, 1'b0, 16'h4321, 16'h1111, 0, 0, 10, 0);
    run_vector("b2b3", 3, 1'b1, 1'b0, 16'h2222, 16'h3333, 0, 0, 72, 0);
    run_vector("backpressure", 1, 1'b1, 1'b0, 16'h4321, 16'h1111, 0, 5, 10, 0);
    run_vector("overrun", 16, 1'b0, 1'b0, 16'h0001, 16'h0001, 0, 0, 16, 1);
    run_vector("full16", 16, 1'b1, 1'b0, 16'h0001, 16'h0001, 0, 0, 16, 0);
    run_vector("gapped", 2, 1'b1, 1'b0, 16'h1111, 16'h1111, 2, 0, 8, 0);
    run_vector("maxlanes", 16, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 0, 1, 14400, 0);

    // Reset in the middle of a four-beat vector
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h1111;
    bus.in_w     = 16'h1111;
    bus.in_last  = 1'b0;
    tick();
    tick();
    check("midrst:psum_before", 32'(psum_in), 32'd4);
    reset = 1'b1;
    #1;
    check("midrst:x", 32'({x3, x2, x1, x0}), 32'd0);
    check("midrst:w", 32'({w3, w2, w1, w0}), 32'd0);
    check("midrst:psum_in", 32'(psum_in), 32'd0);
    check("midrst:out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst:out_data", 32'(bus.out_data), 32'd0);
    check("midrst:out_err", 32'(bus.out_err), 32'd0);
    check("midrst:in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    run_vector("after_rst", 1, 1'b1, 1'b0, 16'h1111, 16'h1111, 0, 0, 4, 0);

    for (int v = 0; v < 25; v++) begin
      n  = int'($urandom_range(1, 16));
      ul = (n < 16) ? 1'b1 : 1'(($urandom_range(0, 1)));
      run_vector("random", n, ul, 1'b1, 16'h0000, 16'h0000, int'($urandom & 32'h0000FFFF),
                 int'($urandom_range(0, 3)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_stream_driver.md
MAC_STREAM_DRIVER -- requirements
Module: mac_stream_driver

Interface
REQ-001 Parameter: bw, 4, operand width per lane, matching mac_wrapper bw.
REQ-002 Parameter: psum_bw, 16, partial-sum width, matching mac_wrapper psum_bw.
REQ-003 Parameter: max_beats, 16, maximum 4-lane beats per vector; a power of two, at least 2.
REQ-004 Port: clk  input  1  single clock, rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: in_valid  input  1  operand beat valid.
REQ-007 Port: in_ready  output  1  driver accepts a beat this cycle.
REQ-008 Port: in_x  input  4*bw  lane operands; lane k is bits [bw*k+bw-1 : bw*k].
REQ-009 Port: in_w  input  4*bw  lane weights; same packing as in_x.
REQ-010 Port: in_last  input  1  the accepted beat is the final beat of the vector.
REQ-011 Port: x0..x3, w0..w3  output  bw each  operands driven to mac_wrapper.
REQ-012 Port: psum_in  output  psum_bw  partial sum driven to mac_wrapper.
REQ-013 Port: mac_out  input  psum_bw  combinational out of mac_wrapper.
REQ-014 Port: out_valid  output  1  result available.
REQ-015 Port: out_ready  input  1  consumer takes the result.
REQ-016 Port: out_data  output  psum_bw  final dot-product result.
REQ-017 Port: out_err  output  1  vector was force-terminated at max_beats; valid with out_valid.

Function
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising clk.
REQ-019 The FSM SHALL have states IDLE, ACC, DRAIN and DONE.
REQ-020 State transitions SHALL be:
- IDLE to ACC on a non-final accept.
- IDLE or ACC to DRAIN on a final accept.
- DRAIN to DONE unconditionally.
- DONE to IDLE when out_ready=1.
REQ-021 in_ready SHALL be 1 in IDLE and ACC, and 0 in DRAIN and DONE; it is a combinational function of state only.
REQ-022 An accepted beat SHALL be registered into x0..x3 and w0..w3 together with a stage-valid bit and a first-beat flag. First-beat flag = the beat was accepted in IDLE.
REQ-023 psum_in SHALL equal 0 when the registered beat is a first beat or stage-valid is 0; otherwise it SHALL equal the psum register.
REQ-024 When stage-valid=1, the psum register SHALL load mac_out on the next edge. Otherwise it holds.
REQ-025 Back-to-back beats SHALL be accepted every cycle with no bubbles; each beat's mac_out is captured in the cycle after acceptance.
REQ-026 Latency: final beat accepted at edge T -> out_valid=1 and out_data = psum register from edge T+2.
REQ-027 out_data and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 A beat counter SHALL count accepted beats per vector. It is cleared in IDLE and is log2(max_beats) bits wide.
REQ-029 The accept that makes the beat count equal max_beats with in_last=0 SHALL be treated as final and SHALL set out_err=1. Otherwise out_err=0.
REQ-030 Arithmetic SHALL be performed in mac_wrapper only. The driver passes operands bit-exact; psum wraps modulo 2^psum_bw with no saturation.
REQ-031 When stage-valid=0, x0..x3 and w0..w3 SHALL be driven to 0.
REQ-032 In DONE, out_valid and out_ready both 1 at an edge SHALL return the FSM to IDLE. in_ready rises in the following cycle; there is no same-cycle input accept.

Reset
REQ-033 Asserting reset SHALL immediately set state=IDLE and clear all of the following to 0:
- x0..x3, w0..w3, psum_in
- psum register, stage-valid, beat counter
- out_valid, out_data, out_err
REQ-034 Reset SHALL discard any in-flight vector. After reset, in_ready=1 in the first cycle.

Verification (bench pairs mac_stream_driver with mac_wrapper, bw=4, psum_bw=16, max_beats=16)
REQ-035 Single beat: x=(1,2,3,4), w=(1,1,1,1), in_last=1 -> out_valid two edges later, out_data=10, out_err=0.
REQ-036 Three back-to-back beats, each x=(2,2,2,2), w=(3,3,3,3), last on beat 3 -> in_ready stays 1 for all three beats, then out_data=72.
REQ-037 Backpressure: out_ready=0 for 5 cycles after a result of 10 -> out_valid, out_data=10 and in_ready=0 all held; on out_ready=1, return to IDLE.
REQ-038 Overrun: 16 beats of x=(1,0,0,0), w=(1,0,0,0), in_last never asserted -> the 16th beat is forced final, out_data=16, out_err=1.
REQ-039 Reset mid-vector after 2 of 4 beats -> all outputs 0 immediately; a following single-beat vector x=(1,1,1,1), w=(1,1,1,1) gives out_data=4.
REQ-040 Gapped input: in_valid toggles 1,0,1 over two beats of (1,1,1,1)x(1,1,1,1) -> out_data=8; psum holds during the gap.
